// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative radix-2 multiply / restoring divide unit with HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] sh_q, sh_d;     // multiplier+product low half / dividend+quotient
  logic [WIDTH-1:0] mc_q, mc_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0] a_q, a_d;
  logic             div_q, div_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;

  logic             w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_sum, w_shl, w_trial;
  logic [WIDTH-1:0] w_step_acc, w_step_sh;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0] w_quo, w_rem;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & a[WIDTH-1];
  assign w_b_neg  = w_signed & b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // One iteration of either algorithm, shared by normal and final steps.
  always_comb begin
    w_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mc_q} : '0);
    w_shl   = {acc_q, sh_q[WIDTH-1]};
    w_trial = w_shl - {1'b0, mc_q};
    if (div_q) begin
      if (!w_trial[WIDTH]) begin
        w_step_acc = w_trial[WIDTH-1:0];
        w_step_sh  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        w_step_acc = w_shl[WIDTH-1:0];
        w_step_sh  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_step_acc = w_sum[WIDTH:1];
      w_step_sh  = {w_sum[0], sh_q[WIDTH-1:1]};
    end
  end

  assign w_prod     = {w_step_acc, w_step_sh};
  assign w_prod_fix = negq_q ? -w_prod : w_prod;
  assign w_quo      = negq_q ? -w_step_sh : w_step_sh;
  assign w_rem      = negr_q ? -w_step_acc : w_step_acc;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    mc_d    = mc_q;
    a_d     = a_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (!op[2]) begin
            state_d = S_RUN;
            cnt_d   = '0;
            acc_d   = '0;
            a_d     = a;
            div_d   = op[1];
            negq_d  = w_a_neg ^ w_b_neg;
            negr_d  = w_a_neg;
            sh_d    = op[1] ? w_a_mag : w_b_mag;
            mc_d    = op[1] ? w_b_mag : w_a_mag;
          end else if (op[1:0] == 2'd0) begin
            hi_d = a;
          end else if (op[1:0] == 2'd1) begin
            lo_d = a;
          end
        end
      end
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = w_step_acc;
          sh_d  = w_step_sh;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = S_DONE;
            if (!div_q) begin
              hi_d = w_prod_fix[2*WIDTH-1:WIDTH];
              lo_d = w_prod_fix[WIDTH-1:0];
            end else if (mc_q == '0) begin
              hi_d = a_q;
              lo_d = '1;
              dz_d = 1'b1;
            end else begin
              hi_d = w_rem;
              lo_d = w_quo;
              dz_d = 1'b0;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      mc_q    <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      mc_q    <= mc_d;
      a_q     <= a_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

`default_nettype wire
